tpu_ctrl: RTL and testbench
===========================

TPU_CTRL -- requirements
Module: tpu_ctrl

Interface
REQ-001 Parameters: DIM=8, systolic dimension; ADDRW=16, host address width; DATAW=64, host data width; BITS_C=16, C element width; DIM*BITS_C SHALL equal 2*DATAW.
REQ-002 Ports: clk in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-003 Ports: req in 1 host access request; r_w in 1 (0 read, 1 write); addr in ADDRW; dataIn in DATAW.
REQ-004 Ports: ready out 1 access accepted when req&ready; rd_valid out 1 C read data valid; err out 1 rejected-access pulse; done out 1 multiply-complete pulse; busy out 1 multiply in progress.
REQ-005 Ports: wdata out DATAW registered write data; a_wr_en out 1; a_row out clog2(DIM); b_en out 1 memB shift/push; mult_en out 1 enable for memA, memB, systolic array; c_wr_en out 1; c_row out clog2(DIM); c_half out 1 selects C row word (0 low, 1 high).

Function
REQ-006 States SHALL be IDLE, COMPUTE, DONE; ready=1 only in IDLE (combinational from state).
REQ-007 Access at cycle N is accepted iff req&ready; all of its effects (strobes, row/half, wdata, rd_valid, err) SHALL appear at cycle N+1 for exactly one cycle, except that row/half/wdata hold until the next accepted access.
REQ-008 Region decode by addr[15:8]: 0x01 A, 0x02 B, 0x03 C, 0x04 control; addr[2:0] ignored.
REQ-009 A write: a_row=addr[3+:clog2(DIM)], a_wr_en=1, wdata=dataIn; offset addr[7:3] >= DIM SHALL give err instead.
REQ-010 B write: b_en=1, wdata=dataIn (one row pushed); offset rule as A.
REQ-011 C write: c_row=addr[4+:clog2(DIM)], c_half=addr[3], c_wr_en=1, wdata=dataIn; addr[7:4] >= DIM gives err.
REQ-012 C read: c_row, c_half as C write, rd_valid=1; data muxing is external.
REQ-013 Control write (any data) at N: state=COMPUTE at N+1; mult_en=1 and busy=1 for exactly 3*DIM-2 cycles (N+1..N+22 for DIM=8); DONE at N+3*DIM-1 with done=1, busy=1; IDLE one cycle later.
REQ-014 b_en SHALL be 1 in every COMPUTE cycle in addition to B-write cycles; a_wr_en, c_wr_en SHALL be 0 in COMPUTE and DONE.
REQ-015 err SHALL pulse at N+1 for: unmapped region, read of A, B or control region, out-of-range offset; no other strobe asserts for that access.
REQ-016 Requests while ready=0 SHALL be ignored (no state change, no err); host holds req until accepted.
REQ-017 Compute counter width clog2(3*DIM); counter SHALL clear on entering COMPUTE and never wrap.
REQ-018 Back-to-back accepted accesses on consecutive IDLE cycles SHALL each produce their own N+1 effects.

Reset
REQ-019 rst_n low SHALL force state IDLE, counter 0, and all outputs 0 (ready=1 once IDLE) asynchronously, including mid-COMPUTE; no done pulse results.
REQ-020 wdata, a_row, c_row, c_half reset to 0.

Structure
REQ-021 Package tpu_pkg SHALL hold the state enum, region constants (A 0x01, B 0x02, C 0x03, CTRL 0x04) and COMPUTE_CYCLES=3*DIM-2.
REQ-022 Address decode SHALL be a combinational sub-module tpu_addr_decode (region, row, half, range-error outputs).

Verification
REQ-023 Write addr 0x0118 data 0x0102030405060708 at N -> N+1: a_wr_en=1, a_row=3, wdata=0x0102030405060708; N+2: a_wr_en=0.
REQ-024 Write 0x0400 at N=10 -> mult_en=1, b_en=1 cycles 11..32, done=1 at 33 only, ready=0 cycles 11..33, ready=1 at 34.
REQ-025 Read 0x0358 at N -> N+1: rd_valid=1, c_row=5, c_half=1; read 0x0140 -> err=1, rd_valid=0.
REQ-026 req with write 0x0100 held during COMPUTE -> no a_wr_en until after IDLE; accepted first IDLE cycle, a_wr_en one cycle later.
REQ-027 rst_n low at cycle 15 of COMPUTE -> immediately mult_en=0, busy=0; after release ready=1, done never pulses.
REQ-028 Write 0x0500 and write 0x0280 -> err pulse each, no strobes; b_en stays 0.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared constants and types for the TPU host-access controller.
package tpu_pkg;

  localparam int unsigned DIM    = 8;
  localparam int unsigned ADDRW  = 16;
  localparam int unsigned DATAW  = 64;
  localparam int unsigned BITS_C = 16;

  localparam int unsigned ROWW           = $clog2(DIM);
  localparam int unsigned COMPUTE_CYCLES = 3 * DIM - 2;
  localparam int unsigned CNTW           = $clog2(3 * DIM);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam logic [7:0] REGION_A    = 8'h01;
  localparam logic [7:0] REGION_B    = 8'h02;
  localparam logic [7:0] REGION_C    = 8'h03;
  localparam logic [7:0] REGION_CTRL = 8'h04;

endpackage

// File: rtl/tpu_ctrl_if.sv
// Host access port plus memory/array control strobes of the TPU controller.
interface tpu_ctrl_if
  import tpu_pkg::*;
();

  logic             req;
  logic             r_w;
  logic [ADDRW-1:0] addr;
  logic [DATAW-1:0] dataIn;

  logic             ready;
  logic             rd_valid;
  logic             err;
  logic             done;
  logic             busy;
  logic [DATAW-1:0] wdata;
  logic             a_wr_en;
  logic [ROWW-1:0]  a_row;
  logic             b_en;
  logic             mult_en;
  logic             c_wr_en;
  logic [ROWW-1:0]  c_row;
  logic             c_half;

  modport master (
    output req, r_w, addr, dataIn,
    input  ready, rd_valid, err, done, busy, wdata,
    input  a_wr_en, a_row, b_en, mult_en, c_wr_en, c_row, c_half
  );

  modport slave (
    input  req, r_w, addr, dataIn,
    output ready, rd_valid, err, done, busy, wdata,
    output a_wr_en, a_row, b_en, mult_en, c_wr_en, c_row, c_half
  );

endinterface

// File: rtl/tpu_addr_decode.sv
// Combinational host address decode: region hits, row/half fields and range errors.
module tpu_addr_decode
  import tpu_pkg::*;
(
  input  logic [ADDRW-1:3] addr_i,
  output logic             hit_a_c_o,
  output logic             hit_b_c_o,
  output logic             hit_c_c_o,
  output logic             hit_ctrl_c_o,
  output logic [ROWW-1:0]  ab_row_c_o,
  output logic [ROWW-1:0]  c_row_c_o,
  output logic             c_half_c_o,
  output logic             ab_oor_c_o,
  output logic             c_oor_c_o
);

  logic [7:0] region;

  assign region       = addr_i[15:8];
  assign hit_a_c_o    = (region == REGION_A);
  assign hit_b_c_o    = (region == REGION_B);
  assign hit_c_c_o    = (region == REGION_C);
  assign hit_ctrl_c_o = (region == REGION_CTRL);

  // A/B rows are 8-byte words; C rows are two words with addr[3] picking the half.
  assign ab_row_c_o = addr_i[3 +: ROWW];
  assign c_row_c_o  = addr_i[4 +: ROWW];
  assign c_half_c_o = addr_i[3];

  assign ab_oor_c_o = (32'(addr_i[7:3]) >= DIM);
  assign c_oor_c_o  = (32'(addr_i[7:4]) >= DIM);

endmodule

// File: rtl/tpu_ctrl.sv
// TPU controller: decodes host accesses into memory strobes and sequences one
// systolic multiply (IDLE -> COMPUTE -> DONE) per control-region write.
module tpu_ctrl
  import tpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  tpu_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [DATAW-1:0] wdata_q, wdata_d;
  logic [ROWW-1:0]  a_row_q, a_row_d;
  logic [ROWW-1:0]  c_row_q, c_row_d;
  logic             c_half_q, c_half_d;
  logic             a_wr_q, a_wr_d;
  logic             b_wr_d;
  logic             c_wr_q, c_wr_d;
  logic             rd_valid_q, rd_valid_d;
  logic             err_q, err_d;
  logic             b_en_q, mult_en_q, busy_q, done_q;

  logic             hit_a, hit_b, hit_c, hit_ctrl;
  logic             ab_oor, c_oor, dec_c_half;
  logic [ROWW-1:0]  dec_ab_row, dec_c_row;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^bus.addr[2:0];

  tpu_addr_decode u_dec (
    .addr_i       (bus.addr[ADDRW-1:3]),
    .hit_a_c_o    (hit_a),
    .hit_b_c_o    (hit_b),
    .hit_c_c_o    (hit_c),
    .hit_ctrl_c_o (hit_ctrl),
    .ab_row_c_o   (dec_ab_row),
    .c_row_c_o    (dec_c_row),
    .c_half_c_o   (dec_c_half),
    .ab_oor_c_o   (ab_oor),
    .c_oor_c_o    (c_oor)
  );

  // Host accesses are only accepted while idle, so ready is a pure state decode.
  assign bus.ready = (state_q == ST_IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    a_row_d    = a_row_q;
    c_row_d    = c_row_q;
    c_half_d   = c_half_q;
    a_wr_d     = 1'b0;
    b_wr_d     = 1'b0;
    c_wr_d     = 1'b0;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          if (hit_a && bus.r_w && !ab_oor) begin
            a_wr_d  = 1'b1;
            a_row_d = dec_ab_row;
            wdata_d = bus.dataIn;
          end else if (hit_b && bus.r_w && !ab_oor) begin
            b_wr_d  = 1'b1;
            wdata_d = bus.dataIn;
          end else if (hit_c && !c_oor) begin
            c_row_d  = dec_c_row;
            c_half_d = dec_c_half;
            if (bus.r_w) begin
              c_wr_d  = 1'b1;
              wdata_d = bus.dataIn;
            end else begin
              rd_valid_d = 1'b1;
            end
          end else if (hit_ctrl && bus.r_w) begin
            state_d = ST_COMPUTE;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        // Counter stops at the last compute cycle, so it can never wrap.
        if (cnt_q == CNTW'(COMPUTE_CYCLES - 1)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs are registered from next-state so they align with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wdata_q    <= '0;
      a_row_q    <= '0;
      c_row_q    <= '0;
      c_half_q   <= 1'b0;
      a_wr_q     <= 1'b0;
      c_wr_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      b_en_q     <= 1'b0;
      mult_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      a_row_q    <= a_row_d;
      c_row_q    <= c_row_d;
      c_half_q   <= c_half_d;
      a_wr_q     <= a_wr_d;
      c_wr_q     <= c_wr_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      b_en_q     <= b_wr_d | (state_d == ST_COMPUTE);
      mult_en_q  <= (state_d == ST_COMPUTE);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
    end
  end

  assign bus.wdata    = wdata_q;
  assign bus.a_wr_en  = a_wr_q;
  assign bus.a_row    = a_row_q;
  assign bus.b_en     = b_en_q;
  assign bus.mult_en  = mult_en_q;
  assign bus.c_wr_en  = c_wr_q;
  assign bus.c_row    = c_row_q;
  assign bus.c_half   = c_half_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.err      = err_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_tpu_ctrl.sv
// Scoreboard bench for tpu_ctrl: expected output snapshots are queued as each
// access is driven and compared cycle by cycle as the controller responds.
module tb_tpu_ctrl;
  import tpu_pkg::*;

  typedef struct packed {
    logic             ready;
    logic             rd_valid;
    logic             err;
    logic             done;
    logic             busy;
    logic [DATAW-1:0] wdata;
    logic             a_wr_en;
    logic [ROWW-1:0]  a_row;
    logic             b_en;
    logic             mult_en;
    logic             c_wr_en;
    logic [ROWW-1:0]  c_row;
    logic             c_half;
  } obs_t;

  logic clk;
  logic rst_n;
  tpu_ctrl_if bus();

  tpu_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks;
  int unsigned failures;
  obs_t        obs;
  obs_t        exp_q[$];

  // Values the controller is expected to be holding between accesses.
  logic [DATAW-1:0] h_wdata;
  logic [ROWW-1:0]  h_a_row;
  logic [ROWW-1:0]  h_c_row;
  logic             h_c_half;

  function automatic obs_t sample();
    obs_t s;
    s.ready    = bus.ready;
    s.rd_valid = bus.rd_valid;
    s.err      = bus.err;
    s.done     = bus.done;
    s.busy     = bus.busy;
    s.wdata    = bus.wdata;
    s.a_wr_en  = bus.a_wr_en;
    s.a_row    = bus.a_row;
    s.b_en     = bus.b_en;
    s.mult_en  = bus.mult_en;
    s.c_wr_en  = bus.c_wr_en;
    s.c_row    = bus.c_row;
    s.c_half   = bus.c_half;
    return s;
  endfunction

  function automatic obs_t base();
    obs_t e;
    e        = '0;
    e.ready  = 1'b1;
    e.wdata  = h_wdata;
    e.a_row  = h_a_row;
    e.c_row  = h_c_row;
    e.c_half = h_c_half;
    return e;
  endfunction

  // Expected outputs k cycles after a control write is accepted.
  function automatic obs_t compute_exp(input int k);
    obs_t e;
    e = base();
    if (k <= int'(COMPUTE_CYCLES)) begin
      e.ready   = 1'b0;
      e.mult_en = 1'b1;
      e.b_en    = 1'b1;
      e.busy    = 1'b1;
    end else if (k == int'(COMPUTE_CYCLES) + 1) begin
      e.ready = 1'b0;
      e.busy  = 1'b1;
      e.done  = 1'b1;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    obs = sample();
  endtask

  task automatic issue(input logic rw, input logic [ADDRW-1:0] a, input logic [DATAW-1:0] d);
    bus.req    = 1'b1;
    bus.r_w    = rw;
    bus.addr   = a;
    bus.dataIn = d;
    tick();
    bus.req = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e;
    rst_n = 1'b0;
    h_wdata = '0; h_a_row = '0; h_c_row = '0; h_c_half = 1'b0;
    exp_q.push_back(base());
    tick();
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_hold got=%h exp=%h", obs, e); end
    rst_n = 1'b1;
    exp_q.push_back(base());
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_release got=%h exp=%h", obs, e); end
  endtask

  task automatic test_a_write();
    obs_t e;
    logic [DATAW-1:0] d;
    d = 64'h0102030405060708;
    h_a_row = 3'd3; h_wdata = d;
    e = base(); e.a_wr_en = 1'b1;
    exp_q.push_back(e);
    exp_q.push_back(base());
    issue(1'b1, 16'h0118, d);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL a_write_n1 got=%h exp=%h", obs, e); end
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL a_write_n2 got=%h exp=%h", obs, e); end
  endtask

  task automatic test_b_write();
    obs_t e;
    logic [DATAW-1:0] d;
    d = 64'hDEADBEEFCAFEF00D;
    h_wdata = d;
    e = base(); e.b_en = 1'b1;
    exp_q.push_back(e);
    exp_q.push_back(base());
    issue(1'b1, 16'h0238, d);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL b_write_n1 got=%h exp=%h", obs, e); end
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL b_write_n2 got=%h exp=%h", obs, e); end
  endtask

  task automatic test_c_access();
    obs_t e;
    logic [DATAW-1:0] d;
    d = 64'h1122334455667788;
    h_c_row = 3'd3; h_c_half = 1'b0; h_wdata = d;
    e = base(); e.c_wr_en = 1'b1;
    exp_q.push_back(e);
    exp_q.push_back(base());
    issue(1'b1, 16'h0330, d);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL c_write got=%h exp=%h", obs, e); end
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL c_write_after got=%h exp=%h", obs, e); end
    h_c_row = 3'd5; h_c_half = 1'b1;
    e = base(); e.rd_valid = 1'b1;
    exp_q.push_back(e);
    exp_q.push_back(base());
    issue(1'b0, 16'h0358, 64'h0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL c_read got=%h exp=%h", obs, e); end
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL c_read_after got=%h exp=%h", obs, e); end
  endtask

  task automatic test_errors();
    obs_t e;
    logic             rw_t [8];
    logic [ADDRW-1:0] ad_t [8];
    rw_t[0] = 1'b1; ad_t[0] = 16'h0500;
    rw_t[1] = 1'b1; ad_t[1] = 16'h0280;
    rw_t[2] = 1'b0; ad_t[2] = 16'h0140;
    rw_t[3] = 1'b0; ad_t[3] = 16'h0200;
    rw_t[4] = 1'b0; ad_t[4] = 16'h0400;
    rw_t[5] = 1'b1; ad_t[5] = 16'h0380;
    rw_t[6] = 1'b0; ad_t[6] = 16'h03F8;
    rw_t[7] = 1'b1; ad_t[7] = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      e = base(); e.err = 1'b1;
      exp_q.push_back(e);
      exp_q.push_back(base());
      issue(rw_t[i], ad_t[i], h_wdata);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL err_pulse[%0d] addr=%h got=%h exp=%h", i, ad_t[i], obs, e); end
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL err_after[%0d] addr=%h got=%h exp=%h", i, ad_t[i], obs, e); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    logic [DATAW-1:0] d [4];
    logic             rw_t [4];
    logic [ADDRW-1:0] ad_t [4];
    d[0] = 64'hA0A0A0A0A0A0A0A0; rw_t[0] = 1'b1; ad_t[0] = 16'h0108;
    d[1] = 64'hB1B1B1B1B1B1B1B1; rw_t[1] = 1'b1; ad_t[1] = 16'h0370;
    d[2] = 64'hC2C2C2C2C2C2C2C2; rw_t[2] = 1'b1; ad_t[2] = 16'h0200;
    d[3] = 64'hD3D3D3D3D3D3D3D3; rw_t[3] = 1'b0; ad_t[3] = 16'h0368;
    for (int i = 0; i < 4; i++) begin
      bus.req = 1'b1; bus.r_w = rw_t[i]; bus.addr = ad_t[i]; bus.dataIn = d[i];
      case (i)
        0: begin h_a_row = 3'd1; h_wdata = d[0]; e = base(); e.a_wr_en = 1'b1; end
        1: begin h_c_row = 3'd7; h_c_half = 1'b0; h_wdata = d[1]; e = base(); e.c_wr_en = 1'b1; end
        2: begin h_wdata = d[2]; e = base(); e.b_en = 1'b1; end
        default: begin h_c_row = 3'd6; h_c_half = 1'b1; e = base(); e.rd_valid = 1'b1; end
      endcase
      exp_q.push_back(e);
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL b2b[%0d] got=%h exp=%h", i, obs, e); end
    end
    bus.req = 1'b0;
    exp_q.push_back(base());
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL b2b_idle got=%h exp=%h", obs, e); end
  endtask

  task automatic test_compute();
    obs_t e;
    for (int k = 1; k <= int'(COMPUTE_CYCLES) + 2; k++) exp_q.push_back(compute_exp(k));
    issue(1'b1, 16'h0400, 64'h5555);
    for (int k = 1; k <= int'(COMPUTE_CYCLES) + 2; k++) begin
      if (k > 1) tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL compute k=%0d got=%h exp=%h", k, obs, e); end
    end
  endtask

  task automatic test_hold_during_compute();
    obs_t e;
    logic [DATAW-1:0] dh;
    int               last;
    dh   = 64'h0F0E0D0C0B0A0908;
    last = int'(COMPUTE_CYCLES) + 4;
    for (int k = 1; k <= int'(COMPUTE_CYCLES) + 2; k++) exp_q.push_back(compute_exp(k));
    h_a_row = 3'd0; h_wdata = dh;
    e = base(); e.a_wr_en = 1'b1;
    exp_q.push_back(e);
    exp_q.push_back(base());
    bus.req = 1'b1; bus.r_w = 1'b1; bus.addr = 16'h0400; bus.dataIn = 64'h0;
    tick();
    bus.addr = 16'h0100; bus.dataIn = dh;
    for (int k = 1; k <= last; k++) begin
      if (k > 1) tick();
      if (k == int'(COMPUTE_CYCLES) + 3) bus.req = 1'b0;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL hold_req k=%0d got=%h exp=%h", k, obs, e); end
    end
  endtask

  task automatic test_reset_mid_compute();
    obs_t e;
    for (int k = 1; k <= 15; k++) exp_q.push_back(compute_exp(k));
    issue(1'b1, 16'h0400, 64'h0);
    for (int k = 1; k <= 15; k++) begin
      if (k > 1) tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL pre_reset k=%0d got=%h exp=%h", k, obs, e); end
    end
    rst_n = 1'b0;
    h_wdata = '0; h_a_row = '0; h_c_row = '0; h_c_half = 1'b0;
    exp_q.push_back(base());
    #1;
    obs = sample();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL async_reset got=%h exp=%h", obs, e); end
    #1;
    rst_n = 1'b1;
    for (int j = 0; j < 30; j++) begin
      exp_q.push_back(base());
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL post_reset j=%0d got=%h exp=%h", j, obs, e); end
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    bus.req    = 1'b0;
    bus.r_w    = 1'b0;
    bus.addr   = '0;
    bus.dataIn = '0;
    test_reset();
    test_a_write();
    test_b_write();
    test_c_access();
    test_errors();
    test_back_to_back();
    test_compute();
    test_hold_during_compute();
    test_reset_mid_compute();
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end
    checks++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
